heap_sort_ctrl: RTL and testbench

// - Upstream sequencer for the heap priority-queue block: accepts a byte stream, pushes each byte into the heap, then pops the heap dry.
// - Emits the bytes as a sorted (ascending, min-first) output stream.
// - Owns the heap's push/pop/done handshake so stream-side logic never sees it.

---
 rtl/heap_sort_ctrl.sv | 161 ++++++++++++++++
 tb/tb_heap_sort_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/heap_sort_ctrl.sv
// Sequencer for the heap priority queue. It pushes each byte of an input batch into the
// heap, then pops the heap dry so the batch comes out in ascending order.
module heap_sort_ctrl #(
    parameter int DW       = 8,
    parameter int CAPACITY = 15,
    parameter int TIMEOUT  = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic          h_push,
    output logic          h_pop,
    output logic [DW-1:0] h_din,
    input  logic [DW-1:0] h_dout,
    input  logic          h_done,
    output logic [7:0]    count,
    output logic          err,
    output logic [2:0]    o_dbg_state
);

    // Stream handshakes: a beat transfers on a rising edge where valid and ready are both 1.
    // The producer holds data, valid and last stable until that edge.
    // The heap side uses 1-cycle push/pop strobes, each answered by one h_done pulse.

    localparam int              WW       = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0]   WAIT_MAX = WW'(TIMEOUT - 1);
    localparam logic [7:0]      CAP8     = 8'(CAPACITY);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PUSH_REQ  = 3'd1,
        ST_PUSH_WAIT = 3'd2,
        ST_POP_REQ   = 3'd3,
        ST_POP_WAIT  = 3'd4,
        ST_OUT_HOLD  = 3'd5
    } state_t;

    state_t        r_state;
    logic [7:0]    r_count;
    logic          r_drain;
    logic          r_err;
    logic [WW-1:0] r_wait;
    logic [DW-1:0] r_h_din;
    logic          r_h_push;
    logic          r_h_pop;
    logic [DW-1:0] r_out_data;
    logic          r_out_valid;
    logic          r_out_last;

    logic w_in_ready;
    logic w_timeout;

    assign w_in_ready = (r_state == ST_IDLE) && (r_count < CAP8) && !r_err;
    assign w_timeout  = (r_wait == WAIT_MAX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_count     <= 8'd0;
            r_drain     <= 1'b0;
            r_err       <= 1'b0;
            r_wait      <= '0;
            r_h_din     <= '0;
            r_h_push    <= 1'b0;
            r_h_pop     <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            // Strobes are set on the transition into a REQ state, so they last one cycle.
            r_h_push <= 1'b0;
            r_h_pop  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && w_in_ready) begin
                        r_h_din  <= in_data;
                        r_drain  <= in_last;
                        r_h_push <= 1'b1;
                        r_state  <= ST_PUSH_REQ;
                    end
                end
                ST_PUSH_REQ: begin
                    r_wait  <= '0;
                    r_state <= ST_PUSH_WAIT;
                end
                ST_PUSH_WAIT: begin
                    if (h_done) begin
                        r_count <= r_count + 8'd1;
                        if (r_drain || (r_count + 8'd1 == CAP8)) begin
                            r_h_pop <= 1'b1;
                            r_state <= ST_POP_REQ;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_count <= 8'd0;
                        r_drain <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                ST_POP_REQ: begin
                    if (r_count == 8'd0) begin
                        r_drain <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_wait  <= '0;
                        r_state <= ST_POP_WAIT;
                    end
                end
                ST_POP_WAIT: begin
                    if (h_done) begin
                        r_out_data  <= h_dout;
                        r_out_valid <= 1'b1;
                        r_out_last  <= (r_count == 8'd1);
                        r_state     <= ST_OUT_HOLD;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_count <= 8'd0;
                        r_drain <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                ST_OUT_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_count     <= r_count - 8'd1;
                        // No pop is issued when this byte was the last one held.
                        r_h_pop     <= (r_count != 8'd1);
                        r_state     <= ST_POP_REQ;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = w_in_ready;
    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign out_last    = r_out_last;
    assign h_push      = r_h_push;
    assign h_pop       = r_h_pop;
    assign h_din       = r_h_din;
    assign count       = r_count;
    assign err         = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_heap_sort_ctrl.sv
// Bench for heap_sort_ctrl: behavioural heap model, table-driven batches, scoreboard queue
// of {last, data} expectations, and hand-written timeout / reset / capacity sequences.
module tb_heap_sort_ctrl;

    localparam int DW       = 8;
    localparam int CAP      = 15;
    localparam int TMO      = 64;
    localparam int HEAP_LAT = 2;
    localparam int BOUND    = 500;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready = 1'b0;
    logic          h_push;
    logic          h_pop;
    logic [DW-1:0] h_din;
    logic [DW-1:0] h_dout = '0;
    logic          h_done;
    logic          h_done_m = 1'b0;
    logic          stray_done = 1'b0;
    logic [7:0]    count;
    logic          err;
    logic [2:0]    dbg_state;

    assign h_done = h_done_m | stray_done;

    always #5 clk = ~clk;

    heap_sort_ctrl #(.DW(DW), .CAPACITY(CAP), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .h_push(h_push), .h_pop(h_pop), .h_din(h_din), .h_dout(h_dout), .h_done(h_done),
        .count(count), .err(err), .o_dbg_state(dbg_state)
    );

    // Heap model: sorted list, fixed latency, optional withholding of push completion.
    logic [DW-1:0] heap_q[$];
    int            op_kind = 0;
    int            op_cnt = 0;
    logic [DW-1:0] op_data = '0;
    int            ins_idx;
    logic          withhold = 1'b0;
    int            n_push = 0;
    int            n_pop = 0;
    int            strobe_err = 0;

    always @(posedge clk) begin
        h_done_m <= 1'b0;
        if (!reset) begin
            heap_q.delete();
            op_kind = 0;
        end else if (h_push || h_pop) begin
            if (op_kind != 0 || (h_push && h_pop)) strobe_err++;
            if (h_push) n_push++;
            if (h_pop) n_pop++;
            op_kind = h_push ? 1 : 2;
            op_data = h_din;
            op_cnt  = HEAP_LAT;
        end else if (op_kind != 0) begin
            if (op_cnt > 1) begin
                op_cnt--;
            end else if (op_kind == 1) begin
                if (!withhold) begin
                    ins_idx = 0;
                    while (ins_idx < heap_q.size() && heap_q[ins_idx] <= op_data) ins_idx++;
                    heap_q.insert(ins_idx, op_data);
                    h_done_m <= 1'b1;
                    op_kind = 0;
                end
            end else begin
                if (heap_q.size() > 0) h_dout <= heap_q.pop_front();
                else h_dout <= '0;
                h_done_m <= 1'b1;
                op_kind = 0;
            end
        end
    end

    int            n_checks = 0;
    int            n_pass = 0;
    logic [DW:0]   exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic send_byte(input logic [DW-1:0] d, input logic last);
        int waited = 0;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && waited < BOUND) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) check("in_ready_wait", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid();
        int waited = 0;
        while (!out_valid && waited < BOUND) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("out_valid_wait", out_valid, 1);
    endtask

    task automatic recv_byte(input int hold);
        logic [DW:0]   e;
        logic [DW-1:0] d0;
        logic          stable;
        int            pops0;
        wait_valid();
        d0     = out_data;
        pops0  = n_pop;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (!out_valid || out_data !== d0) stable = 1'b0;
        end
        if (hold > 0) begin
            check("hold_stable", stable, 1);
            check("hold_no_pop", n_pop, pops0);
        end
        if (exp_q.size() == 0) begin
            check("unexpected_out", out_valid, 0);
        end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e[DW-1:0]);
            check("out_last", out_last, e[DW]);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
    endtask

    typedef struct {
        logic [DW-1:0] din;
        logic          last;
        logic [DW-1:0] exp_d;
        logic          exp_last;
    } vec_t;
    vec_t tbl[4];

    task automatic run_table(input int hold);
        int p0 = n_push;
        int q0 = n_pop;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({tbl[i].exp_last, tbl[i].exp_d});
            send_byte(tbl[i].din, tbl[i].last);
        end
        wait_valid();
        check("count_full_batch", count, 4);
        for (int i = 0; i < 4; i++) recv_byte(hold);
        @(posedge clk);
        #1;
        check("count_after_batch", count, 0);
        check("idle_after_batch", dbg_state, 0);
        check("in_ready_after_batch", in_ready, 1);
        check("push_count_batch", n_push - p0, 4);
        check("pop_count_batch", n_pop - q0, 4);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] vals[$];
        logic          ready_low;
        int            p0;
        int            q0;

        tbl[0] = '{din: 8'd6, last: 1'b0, exp_d: 8'd1, exp_last: 1'b0};
        tbl[1] = '{din: 8'd4, last: 1'b0, exp_d: 8'd2, exp_last: 1'b0};
        tbl[2] = '{din: 8'd2, last: 1'b0, exp_d: 8'd4, exp_last: 1'b0};
        tbl[3] = '{din: 8'd1, last: 1'b1, exp_d: 8'd6, exp_last: 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_h_push", h_push, 0);
        check("rst_h_pop", h_pop, 0);
        check("rst_count", count, 0);
        check("rst_err", err, 0);
        check("rst_state", dbg_state, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);

        // Basic batch, then same batch with a slow consumer
        run_table(0);
        run_table(5);

        // Single byte
        p0 = n_push;
        q0 = n_pop;
        exp_q.push_back({1'b1, 8'h2A});
        send_byte(8'h2A, 1'b1);
        recv_byte(0);
        repeat (3) @(posedge clk);
        #1;
        check("single_push", n_push - p0, 1);
        check("single_pop", n_pop - q0, 1);
        check("single_idle", dbg_state, 0);

        // Capacity-forced drain, then a byte offered during the drain
        vals.delete();
        for (int i = 0; i < CAP; i++) vals.push_back(8'($urandom_range(0, 255)));
        begin
            logic [DW-1:0] sorted[$];
            sorted = vals;
            sorted.sort();
            for (int i = 0; i < CAP; i++) exp_q.push_back({(i == CAP - 1), sorted[i]});
        end
        exp_q.push_back({1'b1, 8'h55});
        for (int i = 0; i < CAP; i++) send_byte(vals[i], 1'b0);
        wait_valid();
        check("cap_count", count, CAP);
        check("cap_in_ready", in_ready, 0);
        fork
            send_byte(8'h55, 1'b1);
            for (int i = 0; i < CAP; i++) recv_byte(0);
        join
        recv_byte(0);
        @(posedge clk);
        #1;
        check("cap_final_count", count, 0);

        // Stray h_done in IDLE
        stray_done = 1'b1;
        @(posedge clk);
        #1;
        stray_done = 1'b0;
        @(posedge clk);
        #1;
        check("stray_state", dbg_state, 0);
        check("stray_count", count, 0);
        check("stray_out_valid", out_valid, 0);

        // Push timeout
        withhold = 1'b1;
        send_byte(8'h77, 1'b1);
        repeat (TMO) @(posedge clk);
        #1;
        check("err_not_early", err, 0);
        @(posedge clk);
        #1;
        check("err_set", err, 1);
        check("err_count", count, 0);
        p0 = n_push;
        in_data   = 8'h11;
        in_valid  = 1'b1;
        ready_low = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (in_ready) ready_low = 1'b0;
        end
        in_valid = 1'b0;
        check("err_in_ready_low", ready_low, 1);
        check("err_no_push", n_push, p0);
        check("err_sticky", err, 1);
        withhold = 1'b0;
        do_reset();
        check("err_cleared", err, 0);

        // Reset while holding an output byte
        for (int i = 0; i < 4; i++) send_byte(tbl[i].din, tbl[i].last);
        wait_valid();
        check("hold_state", dbg_state, 5);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_count", count, 0);
        check("midrst_state", dbg_state, 0);
        reset = 1'b1;
        exp_q.push_back({1'b0, 8'd1});
        exp_q.push_back({1'b1, 8'd3});
        send_byte(8'd3, 1'b0);
        send_byte(8'd1, 1'b1);
        recv_byte(0);
        recv_byte(0);
        @(posedge clk);
        #1;
        check("post_rst_idle", dbg_state, 0);

        check("strobe_rules", strobe_err, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
